// File: rtl/str_byte_buf.sv
// Byte-stream string buffer: fill, random-access GETC/PUTC, then drain. Optional macro STR_BYTE_BUF_TOLOWER_EN.
// Latency: fill/command accept in 1 cycle, rsp 1 cycle after an accepted GETC/PUTC, drain 1 byte/cycle.
// Backpressure: fill never stalls (overflow bytes dropped, ovf set); drain holds data while out_ready=0.
module str_byte_buf #(
    parameter int MAX_LEN = 32,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic [7:0]       cmd_data,
    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             rsp_err,
`ifdef STR_BYTE_BUF_TOLOWER_EN
    input  logic             lower_en,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic [IDX_W:0]   len,
    output logic             ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [1:0] OP_GETC  = 2'b00;
    localparam logic [1:0] OP_PUTC  = 2'b01;
    localparam logic [1:0] OP_DRAIN = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [IDX_W:0] LP_MAX = (IDX_W+1)'(MAX_LEN);
    localparam logic [IDX_W:0] LP_ONE = (IDX_W+1)'(1);

    logic [1:0]       r_state;
    logic [IDX_W:0]   r_len;
    logic             r_ovf;
    logic [IDX_W-1:0] r_rd_ptr;
    logic             r_rsp_valid;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_err;
    logic [7:0]       r_buf [MAX_LEN];

    logic             w_lower;
    logic             w_in_fire;
    logic             w_cmd_fire;
    logic             w_out_fire;
    logic             w_idx_ok;
    logic             w_full;
    logic             w_putc_ok;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [7:0]       w_wr_dat;
    logic [IDX_W:0]   w_len_m1;

`ifdef STR_BYTE_BUF_TOLOWER_EN
    assign w_lower = lower_en;
`else
    assign w_lower = 1'b0;
`endif

    // Lowercase view used on the read paths only; storage always stays raw.
    function automatic logic [7:0] f_map(input logic [7:0] c, input logic en);
        return (en && c >= 8'h41 && c <= 8'h5A) ? (c + 8'h20) : c;
    endfunction

    // rst_n gates in_ready so the source sees no acceptance while reset is held.
    assign in_ready   = rst_n && (r_state == S_IDLE || r_state == S_FILL);
    assign cmd_ready  = (r_state == S_HOLD);
    assign w_in_fire  = in_valid && in_ready;
    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_idx_ok   = ({1'b0, cmd_idx} < r_len);
    assign w_full     = (r_len == LP_MAX);
    assign w_putc_ok  = w_idx_ok && (cmd_data != 8'h00);
    assign w_len_m1   = r_len - LP_ONE;

    assign out_valid  = (r_state == S_DRAIN);
    assign out_data   = out_valid ? f_map(r_buf[r_rd_ptr], w_lower) : 8'h00;
    assign out_last   = out_valid && ({1'b0, r_rd_ptr} == w_len_m1);
    assign w_out_fire = out_valid && out_ready;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_err    = r_rsp_err;
    assign len        = r_len;
    assign ovf        = r_ovf;

    // Single buffer write port shared by fill and PUTC (they never overlap in state).
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        w_wr_dat = in_data;
        if (w_in_fire && r_state == S_IDLE) begin
            w_wr_en  = 1'b1;
        end else if (w_in_fire && r_state == S_FILL && !w_full) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_len[IDX_W-1:0];
        end else if (w_cmd_fire && cmd_op == OP_PUTC && w_putc_ok) begin
            w_wr_en  = 1'b1;
            w_wr_idx = cmd_idx;
            w_wr_dat = cmd_data;
        end
    end

    // Buffer storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_idx] <= w_wr_dat;
        end
    end

    // Control FSM, length/overflow tracking, drain pointer and response pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_rd_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_len   <= LP_ONE;
                        r_state <= in_last ? S_HOLD : S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_in_fire) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_len <= r_len + LP_ONE;
                        end
                        if (in_last) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_cmd_fire) begin
                        case (cmd_op)
                            OP_GETC: begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= !w_idx_ok;
                                r_rsp_data  <= w_idx_ok ? f_map(r_buf[cmd_idx], w_lower) : 8'h00;
                            end
                            OP_PUTC: begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= !w_putc_ok;
                            end
                            OP_DRAIN: begin
                                r_rd_ptr <= '0;
                                r_state  <= S_DRAIN;
                            end
                            OP_CLEAR: begin
                                r_len   <= '0;
                                r_ovf   <= 1'b0;
                                r_state <= S_IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (out_last) begin
                            r_len    <= '0;
                            r_ovf    <= 1'b0;
                            r_rd_ptr <= '0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_str_byte_buf.sv
// Directed bench for str_byte_buf: a 32-entry and a 4-entry instance.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Every wait on the DUT is bounded by a cycle budget.
module tb_str_byte_buf;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_valid4;
    logic [7:0] in_data;
    logic       in_last;
    logic       cmd_valid, cmd_valid4;
    logic [1:0] cmd_op;
    logic [4:0] cmd_idx;
    logic [7:0] cmd_data;
    logic       out_ready;
`ifdef STR_BYTE_BUF_TOLOWER_EN
    logic       lower_en;
`endif

    logic       in_ready, cmd_ready, rsp_valid, rsp_err, out_valid, out_last, ovf;
    logic [7:0] rsp_data, out_data;
    logic [5:0] len;
    logic       in_ready4, cmd_ready4, rsp_valid4, rsp_err4, out_valid4, out_last4, ovf4;
    logic [7:0] rsp_data4, out_data4;
    logic [2:0] len4;

    int n_chk  = 0;
    int n_pass = 0;

    str_byte_buf #(.MAX_LEN(32), .IDX_W(5)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
`ifdef STR_BYTE_BUF_TOLOWER_EN
        .lower_en(lower_en),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .len(len), .ovf(ovf)
    );

    str_byte_buf #(.MAX_LEN(4), .IDX_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data), .in_last(in_last),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_op(cmd_op), .cmd_idx(cmd_idx[1:0]),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .rsp_err(rsp_err4),
`ifdef STR_BYTE_BUF_TOLOWER_EN
        .lower_en(lower_en),
`endif
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_last(out_last4),
        .len(len4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back fill of a whole string; returns how many cycles saw in_ready low.
    task automatic fill(input string s, input bit four, output int rdy_low);
        rdy_low = 0;
        for (int i = 0; i < s.len(); i++) begin
            in_valid  = !four;
            in_valid4 = four;
            in_data   = s[i];
            in_last   = (i == s.len() - 1);
            if (!(four ? in_ready4 : in_ready)) rdy_low++;
            step();
        end
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        in_last   = 1'b0;
    endtask

    // Presents one command for one cycle; caller drops cmd_valid when done.
    task automatic issue(input bit four, input logic [1:0] op, input logic [4:0] idx,
                         input logic [7:0] dat);
        cmd_valid  = !four;
        cmd_valid4 = four;
        cmd_op     = op;
        cmd_idx    = idx;
        cmd_data   = dat;
        step();
    endtask

    task automatic cmd_idle();
        cmd_valid  = 1'b0;
        cmd_valid4 = 1'b0;
    endtask

    // Issues DRAIN and collects bytes; mode 1 stalls with out_ready pattern 1,0,0,1,0,0...
    task automatic drain_chk(input string exp, input bit four, input int mode);
        int         k = 0;
        int         n = 0;
        bit         done = 0;
        bit         stalled = 0;
        logic [7:0] pd = 8'h00;
        logic       v, l;
        logic [7:0] d;
        issue(four, 2'b10, 5'd0, 8'h00);
        cmd_idle();
        while (!done && k < 200) begin
            out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
            #1;
            v = four ? out_valid4 : out_valid;
            d = four ? out_data4  : out_data;
            l = four ? out_last4  : out_last;
            if (stalled) chk("stall_hold", d, pd);
            if (v && out_ready) begin
                if (n < exp.len()) chk("drain_byte", d, exp[n]);
                chk("drain_last", l, (n == exp.len() - 1));
                n++;
                stalled = 0;
                if (l) done = 1;
            end else begin
                stalled = v;
                pd = d;
            end
            @(posedge clk);
            #1;
            k++;
        end
        out_ready = 1'b0;
        chk("drain_done", done, 1);
        chk("drain_count", n, exp.len());
        chk("drain_len0", four ? len4 : len, 0);
        chk("drain_vld0", four ? out_valid4 : out_valid, 0);
    endtask

    initial begin
        int lo;
        rst_n = 1'b1;
        in_valid = 0; in_valid4 = 0; in_data = 0; in_last = 0;
        cmd_valid = 0; cmd_valid4 = 0; cmd_op = 0; cmd_idx = 0; cmd_data = 0;
        out_ready = 0;
`ifdef STR_BYTE_BUF_TOLOWER_EN
        lower_en = 0;
`endif
        #2 rst_n = 1'b0;
        #10;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_len", len, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        #10 rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // Basic fill and drain
        fill("Raghav", 0, lo);
        chk("fill_len", len, 6);
        chk("fill_ovf", ovf, 0);
        chk("hold_cmd_ready", cmd_ready, 1);
        chk("hold_in_ready", in_ready, 0);
        drain_chk("Raghav", 0, 0);

        // Random access, back-to-back commands
        fill("Raghav", 0, lo);
        issue(0, 2'b00, 5'd2, 8'h00);
        chk("getc2_vld", rsp_valid, 1);
        chk("getc2_dat", rsp_data, 8'h67);
        chk("getc2_err", rsp_err, 0);
        issue(0, 2'b00, 5'd6, 8'h00);
        chk("getc6_vld", rsp_valid, 1);
        chk("getc6_dat", rsp_data, 8'h00);
        chk("getc6_err", rsp_err, 1);
        issue(0, 2'b01, 5'd3, 8'h64);
        chk("putc3_vld", rsp_valid, 1);
        chk("putc3_err", rsp_err, 0);
        chk("putc3_dat", rsp_data, 8'h00);
        issue(0, 2'b00, 5'd3, 8'h00);
        chk("getc3_dat", rsp_data, 8'h64);
        chk("getc3_err", rsp_err, 0);
        issue(0, 2'b01, 5'd1, 8'h00);
        chk("putc_nul_err", rsp_err, 1);
        cmd_idle();
        step();
        chk("rsp_pulse_end", rsp_valid, 0);
        chk("putc_len_same", len, 6);
        drain_chk("Ragdav", 0, 0);

        // Overflow on a 4-entry instance
        fill("Aggarwal", 1, lo);
        chk("ovf_len", len4, 4);
        chk("ovf_set", ovf4, 1);
        chk("ovf_no_stall", lo, 0);
        issue(1, 2'b11, 5'd0, 8'h00);
        cmd_idle();
        chk("clear_ovf", ovf4, 0);
        chk("clear_len", len4, 0);
        chk("clear_in_ready", in_ready4, 1);
        fill("Aggarwal", 1, lo);
        drain_chk("Agga", 1, 0);
        chk("drain_ovf_clr", ovf4, 0);

        // Stalled drain
        fill("Raghav", 0, lo);
        drain_chk("Raghav", 0, 1);

        // Reset in the middle of a drain
        fill("Raghav", 0, lo);
        issue(0, 2'b10, 5'd0, 8'h00);
        cmd_idle();
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_vld", out_valid, 0);
        chk("mid_rst_in_rdy", in_ready, 0);
        #3 rst_n = 1'b1;
        step();
        chk("mid_rst_len", len, 0);
        chk("mid_rst_in_rdy1", in_ready, 1);
        chk("mid_rst_out_vld1", out_valid, 0);

`ifdef STR_BYTE_BUF_TOLOWER_EN
        fill("Aggarwal", 0, lo);
        lower_en = 1'b1;
        issue(0, 2'b00, 5'd0, 8'h00);
        chk("lower_getc", rsp_data, 8'h61);
        lower_en = 1'b0;
        issue(0, 2'b00, 5'd0, 8'h00);
        chk("raw_getc", rsp_data, 8'h41);
        cmd_idle();
        lower_en = 1'b1;
        drain_chk("aggarwal", 0, 0);
        lower_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
